// File: rtl/mic1_mem_pkg.sv
`default_nettype none
// ============================================================
// Module : mic1_mem_pkg -- shared encodings for mic1_mem_ctrl
// Rev    : 1.0  initial release
// ============================================================
package mic1_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [1:0] c_KIND_IDLE  = 2'b00;
   localparam logic [1:0] c_KIND_ADDR  = 2'b01;
   localparam logic [1:0] c_KIND_WDATA = 2'b10;
   localparam logic [1:0] c_KIND_RDATA = 2'b11;

   localparam logic REQ_IFU = 1'b0;
   localparam logic REQ_DAT = 1'b1;

   // Byte idx of a word, idx 0 = least-significant byte.
   function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
      return word[{idx, 3'b000} +: 8];
   endfunction

endpackage
`default_nettype wire

// File: rtl/mic1_mem_arb.sv
`default_nettype none
// ============================================================
// Module : mic1_mem_arb -- 2-way fetch/data arbiter
//          (round-robin when MIC1_MEM_RR_ARB_EN is defined)
// Rev    : 1.0  initial release
// ============================================================
module mic1_mem_arb
   import mic1_mem_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic qual,
   input  logic ifu_req,
   input  logic dat_req,
   output logic grant,
   output logic grant_id
);

   logic r_last_dat;
   logic w_tie_to_ifu;

`ifdef MIC1_MEM_RR_ARB_EN
   assign w_tie_to_ifu = r_last_dat;
`else
   logic w_unused_last;
   assign w_unused_last = r_last_dat;
   assign w_tie_to_ifu  = 1'b0;
`endif

   assign grant    = qual & (ifu_req | dat_req);
   assign grant_id = (dat_req & ~(ifu_req & w_tie_to_ifu)) ? REQ_DAT : REQ_IFU;

   // Resets to "fetch last" so data takes the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_last_dat <= 1'b0;
      else if (grant)
         r_last_dat <= (grant_id == REQ_DAT);
   end

endmodule
`default_nettype wire

// File: rtl/mic1_mem_ctrl.sv
`default_nettype none
// ============================================================
// Module : mic1_mem_ctrl -- serialises MIC-1 fetch/data accesses onto
//          an 8-bit bus; option macro MIC1_MEM_RR_ARB_EN (arbiter)
// Rev    : 1.0  initial release
// ============================================================
module mic1_mem_ctrl
   import mic1_mem_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ena,
   input  logic        ifu_req,
   input  logic [31:0] ifu_addr,
   output logic        ifu_done,
   output logic [7:0]  mbr_data,
   input  logic        dat_req,
   input  logic        dat_we,
   input  logic [31:0] dat_addr,
   input  logic [31:0] dat_wdata,
   output logic        dat_done,
   output logic [31:0] mdr_rdata,
   output logic        busy,
   output logic        ext_valid,
   input  logic        ext_ready,
   output logic [1:0]  ext_kind,
   output logic        ext_size,
   output logic [7:0]  ext_out,
   input  logic [7:0]  ext_in
);

   state_t      r_state;
   state_t      w_state_next;
   logic [1:0]  r_bc;
   logic        r_id;
   logic        r_we;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_rbuf;
   logic        w_grant;
   logic        w_grant_id;
   logic        w_xfer;
   logic        w_last_byte;
   logic [1:0]  w_unused_addr_hi;

   assign w_unused_addr_hi = dat_addr[31:30];

   mic1_mem_arb u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .qual     (ena && (r_state == IDLE)),
      .ifu_req  (ifu_req),
      .dat_req  (dat_req),
      .grant    (w_grant),
      .grant_id (w_grant_id)
   );

   assign w_xfer      = ena & ext_valid & ext_ready;
   assign w_last_byte = (r_id == REQ_DAT) ? (r_bc == 2'd3) : (r_bc == 2'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= IDLE;
      else
         r_state <= w_state_next;
   end

   // Every transition is qualified by ena, so ena low holds the state.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_grant) w_state_next = ADDR;
         ADDR:    if (w_xfer && (r_bc == 2'd3)) w_state_next = DATA;
         DATA:    if (w_xfer && w_last_byte) w_state_next = DONE;
         DONE:    if (ena) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bc      <= 2'd0;
         r_id      <= REQ_IFU;
         r_we      <= 1'b0;
         r_addr    <= 32'd0;
         r_wdata   <= 32'd0;
         r_rbuf    <= 32'd0;
         mdr_rdata <= 32'd0;
         mbr_data  <= 8'd0;
      end else if (ena) begin
         if (w_state_next != r_state)
            r_bc <= 2'd0;
         else if (w_xfer)
            r_bc <= r_bc + 2'd1;
         if (w_grant) begin
            r_id    <= w_grant_id;
            r_addr  <= (w_grant_id == REQ_DAT) ? {dat_addr[29:0], 2'b00} : ifu_addr;
            r_we    <= (w_grant_id == REQ_DAT) & dat_we;
            r_wdata <= dat_wdata;
         end
         if (w_xfer && (r_state == DATA) && !r_we) begin
            r_rbuf[{r_bc, 3'b000} +: 8] <= ext_in;
            if (w_last_byte) begin
               if (r_id == REQ_DAT)
                  mdr_rdata <= {ext_in, r_rbuf[23:0]};
               else
                  mbr_data  <= ext_in;
            end
         end
      end
   end

   always_comb begin
      ext_valid = 1'b0;
      ext_kind  = c_KIND_IDLE;
      ext_out   = 8'h00;
      ext_size  = (r_state != IDLE) && (r_id == REQ_DAT);
      busy      = (r_state != IDLE);
      ifu_done  = (r_state == DONE) && (r_id == REQ_IFU);
      dat_done  = (r_state == DONE) && (r_id == REQ_DAT);
      case (r_state)
         ADDR: begin
            ext_valid = 1'b1;
            ext_kind  = c_KIND_ADDR;
            ext_out   = byte_sel(r_addr, r_bc);
         end
         DATA: begin
            ext_valid = 1'b1;
            if (r_we) begin
               ext_kind = c_KIND_WDATA;
               ext_out  = byte_sel(r_wdata, r_bc);
            end else begin
               ext_kind = c_KIND_RDATA;
            end
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_mic1_mem_ctrl.sv
`default_nettype none
// ============================================================
// Module : tb_mic1_mem_ctrl -- scoreboard bench for mic1_mem_ctrl
// Rev    : 1.0  initial release
// ============================================================
module tb_mic1_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ena = 1'b1;
   logic        ifu_req = 1'b0;
   logic [31:0] ifu_addr = '0;
   logic        ifu_done;
   logic [7:0]  mbr_data;
   logic        dat_req = 1'b0;
   logic        dat_we = 1'b0;
   logic [31:0] dat_addr = '0;
   logic [31:0] dat_wdata = '0;
   logic        dat_done;
   logic [31:0] mdr_rdata;
   logic        busy;
   logic        ext_valid;
   logic        ext_ready = 1'b1;
   logic [1:0]  ext_kind;
   logic        ext_size;
   logic [7:0]  ext_out;
   logic [7:0]  ext_in = '0;

   mic1_mem_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .ifu_req   (ifu_req),
      .ifu_addr  (ifu_addr),
      .ifu_done  (ifu_done),
      .mbr_data  (mbr_data),
      .dat_req   (dat_req),
      .dat_we    (dat_we),
      .dat_addr  (dat_addr),
      .dat_wdata (dat_wdata),
      .dat_done  (dat_done),
      .mdr_rdata (mdr_rdata),
      .busy      (busy),
      .ext_valid (ext_valid),
      .ext_ready (ext_ready),
      .ext_kind  (ext_kind),
      .ext_size  (ext_size),
      .ext_out   (ext_out),
      .ext_in    (ext_in)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] kind;
      logic [7:0] data;
      logic       size;
   } beat_t;

   typedef struct {
      logic        is_dat;
      logic [31:0] mdr;
      logic [7:0]  mbr;
   } done_t;

   beat_t       exp_beats[$];
   done_t       exp_dones[$];
   logic [7:0]  rd_q[$];
   logic [31:0] model_mdr = '0;
   logic [7:0]  model_mbr = '0;
   int          n_vec = 0;
   int          n_err = 0;
   logic        rand_env = 1'b0;
   logic        scramble = 1'b0;
   beat_t       mb;
   done_t       md;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: byte stream on the bus plus architectural result.
   task automatic push_txn(input logic is_dat, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rword);
      logic [31:0] baddr;
      beat_t       b;
      done_t       d;
      baddr = is_dat ? (addr << 2) : addr;
      for (int i = 0; i < 4; i++) begin
         b.kind = 2'b01; b.data = 8'(baddr >> (8 * i)); b.size = is_dat;
         exp_beats.push_back(b);
      end
      if (is_dat && we) begin
         for (int i = 0; i < 4; i++) begin
            b.kind = 2'b10; b.data = 8'(wdata >> (8 * i)); b.size = 1'b1;
            exp_beats.push_back(b);
         end
      end else begin
         for (int i = 0; i < (is_dat ? 4 : 1); i++) begin
            b.kind = 2'b11; b.data = 8'(rword >> (8 * i)); b.size = is_dat;
            exp_beats.push_back(b);
            rd_q.push_back(b.data);
         end
         if (is_dat) model_mdr = rword;
         else        model_mbr = rword[7:0];
      end
      d.is_dat = is_dat; d.mdr = model_mdr; d.mbr = model_mbr;
      exp_dones.push_back(d);
   endtask

   task automatic drive_req(input logic is_dat, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata);
      if (is_dat) begin
         dat_req = 1'b1; dat_we = we; dat_addr = addr; dat_wdata = wdata;
      end else begin
         ifu_req = 1'b1; ifu_addr = addr;
      end
   endtask

   task automatic drop_req(input logic is_dat);
      if (is_dat) dat_req = 1'b0;
      else        ifu_req = 1'b0;
   endtask

   // Returns the cycle (0 = first IDLE cycle with req high) in which done was seen.
   task automatic wait_done(input logic is_dat, input int budget, output int lat);
      lat = -1;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (scramble && busy) begin
            dat_addr = $urandom; dat_wdata = $urandom; ifu_addr = $urandom;
            dat_we = 1'($urandom_range(0, 1));
         end
         if (ena && (is_dat ? dat_done : ifu_done)) begin
            lat = c;
            break;
         end
      end
      check("done_within_budget", 32'(lat >= 0), 32'd1);
   endtask

   task automatic run_timed(input logic is_dat, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rword,
                            input int rdy_lo, input int rdy_hi, input int ena_lo, input int ena_hi,
                            input logic [7:0] hold_byte, input int exp_lat);
      int lat;
      lat = -1;
      push_txn(is_dat, we, addr, wdata, rword);
      drive_req(is_dat, we, addr, wdata);
      ext_ready = !(0 >= rdy_lo && 0 <= rdy_hi);
      ena       = !(0 >= ena_lo && 0 <= ena_hi);
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (c >= rdy_lo && c <= rdy_hi) begin
            check("stall_kind_hold", 32'(ext_kind), 32'h1);
            check("stall_byte_hold", 32'(ext_out), 32'(hold_byte));
         end
         if (ena && (is_dat ? dat_done : ifu_done)) begin
            lat = c;
            break;
         end
         @(posedge clk); #1;
         ext_ready = !((c + 1) >= rdy_lo && (c + 1) <= rdy_hi);
         ena       = !((c + 1) >= ena_lo && (c + 1) <= ena_hi);
      end
      check("latency", 32'(lat), 32'(exp_lat));
      @(posedge clk); #1;
      drop_req(is_dat);
      ena = 1'b1; ext_ready = 1'b1;
   endtask

   // Memory side: present the next expected read byte; the monitor consumes it.
   always @(posedge clk) begin
      #1;
      ext_in = (rd_q.size() > 0) ? rd_q[0] : 8'h00;
   end

   always @(posedge clk) begin
      #1;
      if (rand_env) begin
         ena       = ($urandom_range(0, 9) != 0);
         ext_ready = ($urandom_range(0, 3) != 0);
      end
   end

   always @(negedge clk) begin
      if (rst_n && ena) begin
         if (ext_valid && ext_ready) begin
            check("beat_expected", 32'(exp_beats.size() > 0), 32'd1);
            if (exp_beats.size() > 0) begin
               mb = exp_beats.pop_front();
               check("beat_kind", 32'(ext_kind), 32'(mb.kind));
               check("beat_size", 32'(ext_size), 32'(mb.size));
               if (mb.kind != 2'b11)
                  check("beat_byte", 32'(ext_out), 32'(mb.data));
               else if (rd_q.size() > 0)
                  void'(rd_q.pop_front());
            end
         end
         if (ifu_done || dat_done) begin
            check("done_expected", 32'(exp_dones.size() > 0), 32'd1);
            if (exp_dones.size() > 0) begin
               md = exp_dones.pop_front();
               check("done_ifu", 32'(ifu_done), 32'(!md.is_dat));
               check("done_dat", 32'(dat_done), 32'(md.is_dat));
               check("mdr_rdata", mdr_rdata, md.mdr);
               check("mbr_data", 32'(mbr_data), 32'(md.mbr));
               check("done_bus_idle", 32'({ext_valid, ext_kind}), 32'd0);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat;
      logic        is_dat, we;
      logic [31:0] a, wd, rw;

      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ext_valid", 32'(ext_valid), 32'd0);
      check("rst_ext_kind",  32'(ext_kind),  32'd0);
      check("rst_ext_size",  32'(ext_size),  32'd0);
      check("rst_ext_out",   32'(ext_out),   32'd0);
      check("rst_dones",     32'({ifu_done, dat_done}), 32'd0);
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_mdr",       mdr_rdata,      32'd0);
      check("rst_mbr",       32'(mbr_data),  32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Simultaneous requests.
      push_txn(1'b1, 1'b0, 32'h0000_0100, 32'd0, $urandom);
      push_txn(1'b0, 1'b0, 32'h0000_2001, 32'd0, $urandom);
`ifdef MIC1_MEM_RR_ARB_EN
      push_txn(1'b1, 1'b0, 32'h0000_0100, 32'd0, $urandom);
`endif
      drive_req(1'b1, 1'b0, 32'h0000_0100, 32'd0);
      drive_req(1'b0, 1'b0, 32'h0000_2001, 32'd0);
      wait_done(1'b1, 50, lat);
      check("tie_first_latency", 32'(lat), 32'd9);
      @(posedge clk); #1;
`ifndef MIC1_MEM_RR_ARB_EN
      dat_req = 1'b0;
`endif
      wait_done(1'b0, 50, lat);
      check("tie_second_latency", 32'(lat), 32'd6);
      @(posedge clk); #1;
      ifu_req = 1'b0;
`ifdef MIC1_MEM_RR_ARB_EN
      wait_done(1'b1, 50, lat);
      check("tie_third_latency", 32'(lat), 32'd9);
      @(posedge clk); #1;
      dat_req = 1'b0;
`endif
      @(posedge clk); #1;

      // Directed transactions from the plan.
      run_timed(1'b1, 1'b0, 32'h0000_0010, 32'd0, 32'h4433_2211, -1, -2, -1, -2, 8'h00, 9);
      run_timed(1'b1, 1'b1, 32'h0000_0001, 32'hDEAD_BEEF, 32'd0, -1, -2, -1, -2, 8'h00, 9);
      run_timed(1'b0, 1'b0, 32'h0102_0304, 32'd0, 32'h0000_00A5, -1, -2, -1, -2, 8'h00, 6);
      run_timed(1'b0, 1'b0, 32'h0102_0304, 32'd0, 32'h0000_005A, 3, 5, -1, -2, 8'h02, 9);
      run_timed(1'b1, 1'b0, 32'hC000_0007, 32'd0, 32'h8877_6655, -1, -2, 6, 7, 8'h00, 11);

      // Reset during DATA byte 1 of a read.
      push_txn(1'b1, 1'b0, 32'h0000_0020, 32'd0, 32'h1234_5678);
      drive_req(1'b1, 1'b0, 32'h0000_0020, 32'd0);
      repeat (7) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_ext_valid", 32'(ext_valid), 32'd0);
      check("arst_busy",      32'(busy),      32'd0);
      check("arst_dat_done",  32'(dat_done),  32'd0);
      check("arst_mdr",       mdr_rdata,      32'd0);
      check("arst_mbr",       32'(mbr_data),  32'd0);
      exp_beats.delete(); exp_dones.delete(); rd_q.delete();
      model_mdr = '0; model_mbr = '0;
      dat_req = 1'b0;
      @(posedge clk); #3;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      run_timed(1'b1, 1'b0, 32'h0000_0030, 32'd0, 32'hCAFE_F00D, -1, -2, -1, -2, 8'h00, 9);

      // Randomised traffic with random ena/ext_ready.
      rand_env = 1'b1;
      scramble = 1'b1;
      for (int t = 0; t < 40; t++) begin
         is_dat = 1'($urandom_range(0, 1));
         we     = 1'($urandom_range(0, 1));
         a = $urandom; wd = $urandom; rw = $urandom;
         push_txn(is_dat, we, a, wd, rw);
         drive_req(is_dat, we, a, wd);
         wait_done(is_dat, 300, lat);
         @(posedge clk); #1;
         drop_req(is_dat);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
      rand_env = 1'b0;
      scramble = 1'b0;
      ena = 1'b1; ext_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("beats_drained", 32'(exp_beats.size()), 32'd0);
      check("dones_drained", 32'(exp_dones.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
